// File: rtl/led_event_flasher.sv
// Turns single-cycle game-event pulses (miss/hit/sunk/win) into tick-paced LED patterns,
// with a one-deep pending slot so an event arriving mid-pattern plays next.
//
// state | meaning
// IDLE  | LEDs dark, any event accepted
// SHOW  | MISS/HIT/SUNK pattern stepping on tick, one event may queue
// WIN   | alternating AA/55 until clr, events refused
module led_event_flasher #(
    parameter int MISS_BLINKS = 2,
    parameter int HIT_BLINKS  = 3,
    parameter int SUNK_LAPS   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       evt_valid,
    input  logic [1:0] evt_code,
    output logic       evt_ready,
    output logic       evt_drop,
    input  logic       clr,
    output logic [7:0] led,
    output logic       busy
);
    localparam int MISS_LAST = 2 * MISS_BLINKS - 1;
    localparam int HIT_LAST  = 2 * HIT_BLINKS - 1;
    localparam int SUNK_LAST = 8 * SUNK_LAPS - 1;
    localparam int MAX_LAST  = (MISS_LAST > HIT_LAST) ?
                               ((MISS_LAST > SUNK_LAST) ? MISS_LAST : SUNK_LAST) :
                               ((HIT_LAST > SUNK_LAST) ? HIT_LAST : SUNK_LAST);
    // at least 3 bits so the chase position is always step[2:0]
    localparam int SW = ($clog2(MAX_LAST + 1) < 3) ? 3 : $clog2(MAX_LAST + 1);

    localparam logic [1:0] C_MISS = 2'd0;
    localparam logic [1:0] C_HIT  = 2'd1;
    localparam logic [1:0] C_WIN  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_WIN} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] step, step_nxt;
    logic [1:0]    code, code_nxt;
    logic [7:0]    led_nxt;
    logic          pend_valid, pend_valid_nxt;
    logic [1:0]    pend_code, pend_code_nxt;
    logic          accept, at_end, do_start;
    logic [1:0]    start_code;

    function automatic logic [7:0] frame(input logic [1:0] c, input logic [SW-1:0] s);
        case (c)
            C_MISS:  frame = s[0] ? 8'h00 : 8'h01;
            C_HIT:   frame = s[0] ? 8'h00 : 8'hFF;
            default: frame = 8'h01 << s[2:0];
        endcase
    endfunction

    function automatic logic [SW-1:0] last_step(input logic [1:0] c);
        case (c)
            C_MISS:  last_step = SW'(MISS_LAST);
            C_HIT:   last_step = SW'(HIT_LAST);
            default: last_step = SW'(SUNK_LAST);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            step       <= '0;
            code       <= '0;
            led        <= 8'h00;
            pend_valid <= 1'b0;
            pend_code  <= '0;
            busy       <= 1'b0;
            evt_drop   <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            code       <= code_nxt;
            led        <= led_nxt;
            pend_valid <= pend_valid_nxt;
            pend_code  <= pend_code_nxt;
            busy       <= (state_nxt != S_IDLE);
            evt_drop   <= evt_valid & ~evt_ready;
        end
    end

    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        code_nxt       = code;
        led_nxt        = led;
        pend_valid_nxt = pend_valid;
        pend_code_nxt  = pend_code;
        do_start       = 1'b0;
        start_code     = evt_code;
        at_end         = tick & (step == last_step(code));
        case (state)
            S_IDLE: begin
                if (accept) do_start = 1'b1;
            end
            S_SHOW: begin
                if (at_end) begin
                    if (pend_valid) begin
                        do_start       = 1'b1;
                        start_code     = pend_code;
                        pend_valid_nxt = 1'b0;
                    end else if (accept) begin
                        do_start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        step_nxt  = '0;
                        led_nxt   = 8'h00;
                    end
                end else begin
                    if (tick) begin
                        step_nxt = step + SW'(1);
                        led_nxt  = frame(code, step + SW'(1));
                    end
                    if (accept) begin
                        pend_valid_nxt = 1'b1;
                        pend_code_nxt  = evt_code;
                    end
                end
            end
            S_WIN: begin
                if (clr) begin
                    state_nxt      = S_IDLE;
                    led_nxt        = 8'h00;
                    pend_valid_nxt = 1'b0;
                end else if (tick) begin
                    led_nxt = (led == 8'hAA) ? 8'h55 : 8'hAA;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (do_start) begin
            code_nxt = start_code;
            step_nxt = '0;
            if (start_code == C_WIN) begin
                state_nxt = S_WIN;
                led_nxt   = 8'hAA;
            end else begin
                state_nxt = S_SHOW;
                led_nxt   = frame(start_code, '0);
            end
        end
    end

    always_comb begin
        evt_ready = (state == S_IDLE) | ((state == S_SHOW) & ~pend_valid);
        accept    = evt_valid & evt_ready;
    end
endmodule

// File: tb/tb_led_event_flasher.sv
// Directed bench for led_event_flasher: a pattern-list model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_led_event_flasher;
    localparam int MB = 2, HB = 3, SL = 2;

    logic       clk = 0, rst_n = 0, tick = 0, evt_valid = 0, clr = 0;
    logic [1:0] evt_code = 0;
    logic       evt_ready, evt_drop, busy;
    logic [7:0] led;

    int total = 0, bad = 0;

    led_event_flasher #(.MISS_BLINKS(MB), .HIT_BLINKS(HB), .SUNK_LAPS(SL)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_ready(evt_ready), .evt_drop(evt_drop),
        .clr(clr), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // model: 0 idle, 1 pattern, 2 win; a pattern is a precomputed list of LED frames
    int m_state, m_len, m_idx, m_led, m_pcode;
    int m_pat[64];
    bit m_pend, m_drop;

    function automatic void m_start(input int c);
        if (c == 3) begin
            m_state = 2;
            m_led   = 'hAA;
        end else begin
            m_state = 1;
            m_len   = (c == 0) ? 2 * MB : (c == 1) ? 2 * HB : 8 * SL;
            for (int i = 0; i < m_len; i++)
                m_pat[i] = (c == 2) ? (1 << (i % 8)) : (i % 2 != 0) ? 0 : (c == 0) ? 'h01 : 'hFF;
            m_idx = 0;
            m_led = m_pat[0];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy, acc, fin;
        if (!rst_n) begin
            m_state = 0; m_led = 0; m_pend = 0; m_drop = 0; m_idx = 0;
        end else begin
            rdy    = (m_state == 0) || (m_state == 1 && !m_pend);
            acc    = evt_valid && rdy;
            m_drop = evt_valid && !rdy;
            if (m_state == 0) begin
                if (acc) m_start(evt_code);
            end else if (m_state == 1) begin
                fin = tick && (m_idx == m_len - 1);
                if (fin) begin
                    if (m_pend) begin
                        m_pend = 0;
                        m_start(m_pcode);
                    end else if (acc) begin
                        m_start(evt_code);
                    end else begin
                        m_state = 0;
                        m_led   = 0;
                    end
                end else begin
                    if (tick) begin
                        m_idx++;
                        m_led = m_pat[m_idx];
                    end
                    if (acc) begin
                        m_pend  = 1;
                        m_pcode = evt_code;
                    end
                end
            end else begin
                if (clr) begin
                    m_state = 0; m_led = 0; m_pend = 0;
                end else if (tick) begin
                    m_led = (m_led == 'hAA) ? 'h55 : 'hAA;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("led", led, m_led);
            check("busy", busy, m_state != 0);
            check("evt_drop", evt_drop, m_drop);
            check("evt_ready", evt_ready, (m_state == 0) || (m_state == 1 && !m_pend));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        tick = 1;
        cyc(1);
        tick = 0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic pulse(input logic [1:0] c);
        evt_valid = 1;
        evt_code  = c;
        cyc(1);
        evt_valid = 0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1;
        cyc(2);
        check("reset_led", led, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_ready", evt_ready, 1);

        // async reset mid-SUNK
        pulse(2);
        check("sunk_first", led, 8'h01);
        ticks(3);
        check("sunk_step3", led, 8'h08);
        #2 rst_n = 0;
        #1;
        check("async_led", led, 8'h00);
        check("async_busy", busy, 0);
        check("async_ready", evt_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        cyc(3);
        check("post_reset_led", led, 8'h00);
        check("post_reset_busy", busy, 0);

        // MISS
        pulse(0);
        check("miss_f0", led, 8'h01);
        check("miss_busy", busy, 1);
        cyc(1);
        do_tick(); check("miss_f1", led, 8'h00);
        do_tick(); check("miss_f2", led, 8'h01);
        do_tick(); check("miss_f3", led, 8'h00);
        check("miss_busy_f3", busy, 1);
        do_tick();
        check("miss_end_led", led, 8'h00);
        check("miss_end_busy", busy, 0);

        // tick and accept together in IDLE: accept wins, no step
        tick = 1;
        pulse(0);
        tick = 0;
        check("idle_tick_accept", led, 8'h01);
        do_tick(); check("idle_tick_next", led, 8'h00);
        ticks(3);
        check("idle_tick_done", busy, 0);

        // back-to-back: HIT, SUNK queued, MISS dropped, clr ignored
        pulse(1);
        check("hit_f0", led, 8'hFF);
        cyc(1);
        pulse(2);
        check("queued_ready", evt_ready, 0);
        pulse(0);
        check("full_drop", evt_drop, 1);
        cyc(1);
        check("drop_clears", evt_drop, 0);
        clr = 1;
        cyc(1);
        clr = 0;
        check("clr_ignored", led, 8'hFF);
        ticks(5);
        check("hit_f5", led, 8'h00);
        do_tick();
        check("sunk_after_hit", led, 8'h01);
        check("sunk_after_busy", busy, 1);
        ticks(7); check("sunk_s7", led, 8'h80);
        do_tick(); check("sunk_lap2", led, 8'h01);
        ticks(7); check("sunk_s15", led, 8'h80);
        do_tick();
        check("sunk_end_led", led, 8'h00);
        check("sunk_end_busy", busy, 0);

        // bypass on the final tick
        pulse(1);
        ticks(5);
        tick = 1; evt_valid = 1; evt_code = 2;
        cyc(1);
        tick = 0; evt_valid = 0;
        check("bypass_led", led, 8'h01);
        check("bypass_busy", busy, 1);
        check("bypass_ready", evt_ready, 1);
        ticks(16);
        check("bypass_done", busy, 0);

        // WIN
        pulse(3);
        check("win_aa", led, 8'hAA);
        check("win_busy", busy, 1);
        do_tick(); check("win_55", led, 8'h55);
        do_tick(); check("win_aa2", led, 8'hAA);
        evt_valid = 1; evt_code = 1;
        #1 check("win_ready", evt_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("win_drop", evt_drop, 1);
        end
        evt_valid = 0;
        cyc(1);
        check("win_drop_end", evt_drop, 0);
        clr = 1;
        cyc(1);
        clr = 0;
        check("win_clr_led", led, 8'h00);
        check("win_clr_busy", busy, 0);

        // pending WIN after HIT
        pulse(1);
        pulse(3);
        check("pend_win_ready", evt_ready, 0);
        ticks(5);
        check("pend_hit_f5", led, 8'h00);
        check("pend_hit_busy", busy, 1);
        do_tick();
        check("pend_win_led", led, 8'hAA);
        check("pend_win_busy", busy, 1);
        do_tick(); check("pend_win_55", led, 8'h55);
        clr = 1;
        cyc(1);
        clr = 0;
        cyc(1);
        check("final_led", led, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
